// File: rtl/debug_view_engine.sv
// debug_view_engine: lane-loaded switch word plus manual/auto-scan/freeze probe word viewer
// Ports: clock/reset (sync, active-high); probe_bus flat probe words; select manual index;
// mode 00/11 manual, 01 auto-scan, 10 freeze; load/lane/lane_data edge-triggered lane write;
// ack clears view_changed; switch_word/switch_nonzero user word; view_index/view_word display;
// view_changed sticky flag for a word change under a constant index.
module debug_view_engine #(
  parameter int WORD_WIDTH   = 16,
  parameter int NUM_WORDS    = 32,
  parameter int LANE_WIDTH   = 8,
  parameter int DWELL_CYCLES = 50000000,
  localparam int SEL_W  = $clog2(NUM_WORDS),
  localparam int NLANES = WORD_WIDTH / LANE_WIDTH,
  localparam int LANE_W = NLANES > 1 ? $clog2(NLANES) : 1,
  localparam int CNT_W  = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [WORD_WIDTH*NUM_WORDS-1:0] probe_bus,
  input  logic [SEL_W-1:0]                select,
  input  logic [1:0]                      mode,
  input  logic                            load,
  input  logic [LANE_W-1:0]               lane,
  input  logic [LANE_WIDTH-1:0]           lane_data,
  input  logic                            ack,
  output logic [WORD_WIDTH-1:0]           switch_word,
  output logic                            switch_nonzero,
  output logic [SEL_W-1:0]                view_index,
  output logic [WORD_WIDTH-1:0]           view_word,
  output logic                            view_changed
);
  logic [WORD_WIDTH-1:0] words [NUM_WORDS];
  logic [WORD_WIDTH-1:0] sw_n, nword;
  logic [SEL_W-1:0]      next_idx, inc_idx;
  logic [CNT_W-1:0]      cnt;
  logic                  load_q, auto, frz, wrap;
  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_w
    assign words[i] = probe_bus[i*WORD_WIDTH +: WORD_WIDTH];
  end
  assign auto    = mode == 2'b01;
  assign frz     = mode == 2'b10;
  assign wrap    = cnt == CNT_W'(DWELL_CYCLES - 1);
  assign inc_idx = view_index == SEL_W'(NUM_WORDS - 1) ? '0 : view_index + 1'b1;
  assign next_idx = auto ? (wrap ? inc_idx : view_index) :
                    frz  ? view_index :
                    (32'(select) < NUM_WORDS ? select : view_index);
  assign nword = words[next_idx];
  always_comb begin
    sw_n = switch_word;
    for (int i = 0; i < NLANES; i++)
      if (load && !load_q && 32'(lane) == i) sw_n[i*LANE_WIDTH +: LANE_WIDTH] = lane_data;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      switch_word    <= '0;
      switch_nonzero <= 1'b0;
      view_index     <= '0;
      view_word      <= '0;
      view_changed   <= 1'b0;
      cnt            <= '0;
      load_q         <= 1'b1;
    end else begin
      load_q         <= load;
      switch_word    <= sw_n;
      switch_nonzero <= |sw_n;
      cnt            <= auto && !wrap ? cnt + 1'b1 : '0;
      view_index     <= next_idx;
      if (!frz) view_word <= nword;
      // an index move always clears; a real change beats a coincident ack
      if (next_idx != view_index) view_changed <= 1'b0;
      else if (!frz && nword != view_word) view_changed <= 1'b1;
      else if (ack) view_changed <= 1'b0;
    end
  end
endmodule

// File: tb/tb_debug_view_engine.sv
// tb_debug_view_engine: directed bench with a spec-level reference model and per-cycle compare
module tb_debug_view_engine;
  localparam int W = 16, N = 4, LW = 8, D = 4;
  logic clock = 0, reset = 1, load = 1, ack = 0;
  logic [W*N-1:0] probe_bus = '0;
  logic [1:0] select = 0, mode = 0;
  logic [0:0] lane = 0;
  logic [LW-1:0] lane_data = 0;
  logic [W-1:0] switch_word, view_word;
  logic switch_nonzero, view_changed;
  logic [1:0] view_index;
  int vec = 0, mis = 0;
  bit started = 0;
  int m_idx, m_cnt;
  logic [W-1:0] m_sw, m_word;
  logic m_chg, m_lq;

  debug_view_engine #(.WORD_WIDTH(W), .NUM_WORDS(N), .LANE_WIDTH(LW), .DWELL_CYCLES(D)) dut (
    .clock(clock), .reset(reset), .probe_bus(probe_bus), .select(select), .mode(mode),
    .load(load), .lane(lane), .lane_data(lane_data), .ack(ack), .switch_word(switch_word),
    .switch_nonzero(switch_nonzero), .view_index(view_index), .view_word(view_word),
    .view_changed(view_changed));

  always #5 clock = ~clock;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    vec++;
    if (a !== e) begin
      mis++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
    end
  endtask

  // reference model: what the display must show after each edge
  always @(posedge clock) begin
    int ni;
    logic [W-1:0] w;
    started = 1;
    if (reset) begin
      m_sw = 0; m_idx = 0; m_word = 0; m_chg = 0; m_cnt = 0; m_lq = 1;
    end else begin
      if (load && !m_lq && int'(lane) < W / LW) m_sw[int'(lane)*LW +: LW] = lane_data;
      m_lq = load;
      if (mode == 2'b01) ni = (m_cnt == D - 1) ? (m_idx + 1) % N : m_idx;
      else if (mode == 2'b10) ni = m_idx;
      else ni = int'(select) < N ? int'(select) : m_idx;
      w = probe_bus[ni*W +: W];
      if (ni != m_idx) m_chg = 0;
      else if (mode != 2'b10 && w != m_word) m_chg = 1;
      else if (ack) m_chg = 0;
      m_cnt = mode == 2'b01 ? (m_cnt + 1) % D : 0;
      m_idx = ni;
      if (mode != 2'b10) m_word = w;
    end
  end

  always @(negedge clock) if (started) begin
    chk("switch_word", 32'(switch_word), 32'(m_sw));
    chk("switch_nonzero", 32'(switch_nonzero), 32'(|m_sw));
    chk("view_index", 32'(view_index), 32'(m_idx));
    chk("view_word", 32'(view_word), 32'(m_word));
    chk("view_changed", 32'(view_changed), 32'(m_chg));
  end

  task automatic step(int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic setw(int i, logic [W-1:0] v);
    probe_bus[i*W +: W] = v;
  endtask

  initial begin
    step(1);
    reset = 0;
    step(1);
    chk("t1 load held thru reset", 32'(switch_word), 32'h0000);
    load = 0; step(1);
    lane = 1; lane_data = 8'hA5; load = 1; step(1);
    chk("t1 lane1 write", 32'(switch_word), 32'hA500);
    chk("t1 nonzero", 32'(switch_nonzero), 1);
    step(2);
    chk("t1 held load writes once", 32'(switch_word), 32'hA500);
    load = 0; step(1);
    lane = 0; lane_data = 8'h3C; load = 1; step(1);
    chk("t1 lane0 write", 32'(switch_word), 32'hA53C);
    load = 0;
    setw(0, 16'h1111); setw(1, 16'h2222); setw(2, 16'h3333); setw(3, 16'h4444);
    select = 2; step(1);
    chk("t2 idx2", 32'(view_index), 2);
    chk("t2 word2", 32'(view_word), 32'h3333);
    select = 3; step(1);
    chk("t2 word3", 32'(view_word), 32'h4444);
    mode = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      chk("t3 scan idx", 32'(view_index), 32'((3 + k / 4) % 4));
    end
    mode = 2'b00; select = 1; setw(1, 16'h1234); step(2);
    chk("t4 steady", 32'(view_changed), 0);
    setw(1, 16'h1235); step(1);
    chk("t4 change sets", 32'(view_changed), 1);
    setw(1, 16'h1236); ack = 1; step(1);
    chk("t4 change beats ack", 32'(view_changed), 1);
    step(1);
    chk("t4 ack clears", 32'(view_changed), 0);
    ack = 0; setw(1, 16'h1237); step(1);
    chk("t4 reset flag", 32'(view_changed), 1);
    select = 2; step(1);
    chk("t4 select clears", 32'(view_changed), 0);
    setw(1, 16'h2222); select = 1; step(1);
    chk("t5 showing", 32'(view_word), 32'h2222);
    mode = 2'b10; step(1);
    setw(1, 16'hFFFF); step(3);
    chk("t5 frozen word", 32'(view_word), 32'h2222);
    chk("t5 frozen flag", 32'(view_changed), 0);
    mode = 2'b00; step(1);
    chk("t5 thaw word", 32'(view_word), 32'hFFFF);
    chk("t5 thaw flag", 32'(view_changed), 1);
    mode = 2'b01; step(2);
    reset = 1; step(1);
    chk("t6 reset idx", 32'(view_index), 0);
    chk("t6 reset word", 32'(view_word), 0);
    chk("t6 reset sw", 32'(switch_word), 0);
    reset = 0;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      chk("t6 dwell after reset", 32'(view_index), k == 4 ? 1 : 0);
    end
    mode = 2'b11; select = 3; step(1);
    chk("t6 mode11 manual", 32'(view_word), 32'h4444);
    step(1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
